gsensor_spi_sequencer: RTL and testbench

Sequences the 3-wire SPI transaction engine for the on-board ADXL345 accelerometer. After reset it waits out sensor power-up, writes a fixed five-register init table, then periodically reads the six data registers. It presents coherent signed X/Y/Z samples to the host logic with a one-cycle valid strobe. It sits between the host-side sample consumers and the SPI engine's parallel command/data port, in the iSPI_CLK domain.

---
 rtl/gsensor_pkg.sv | 51 +++++
 rtl/gsensor_init_rom.sv | 19 +
 rtl/gsensor_spi_sequencer.sv | 178 +++++++++++++++++
 tb/tb_gsensor_spi_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_pkg.sv
// rtl/gsensor_pkg.sv - ADXL345 register map, init table, sequencer states and command-word helper
package gsensor_pkg;

  localparam logic [5:0] DATA_FORMAT = 6'h31;
  localparam logic [5:0] BW_RATE     = 6'h2C;
  localparam logic [5:0] INT_MAP     = 6'h2F;
  localparam logic [5:0] INT_ENABLE  = 6'h2E;
  localparam logic [5:0] POWER_CTL   = 6'h2D;
  localparam logic [5:0] DATAX0      = 6'h32;

  localparam int RW_BIT    = 15;
  localparam int MB_BIT    = 14;
  localparam int INIT_LEN  = 5;
  localparam int NUM_READS = 6;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } initEntry_t;

  // DATA_FORMAT goes first so the sensor is in 3-wire mode before anything is read back
  localparam initEntry_t INIT_TABLE [INIT_LEN] = '{
    '{DATA_FORMAT, 8'h4B},
    '{BW_RATE,     8'h0A},
    '{INT_MAP,     8'h00},
    '{INT_ENABLE,  8'h80},
    '{POWER_CTL,   8'h08}
  };

  typedef enum logic [3:0] {
    S_PWRUP,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_INIT_GAP,
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_GAP,
    S_PUBLISH
  } state_t;

  function automatic logic [15:0] cmdWord(input logic rd, input logic [5:0] addr,
                                          input logic [7:0] data);
    logic [15:0] w;
    w = {2'b00, addr, data};
    w[RW_BIT] = rd;
    w[MB_BIT] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/gsensor_init_rom.sv
// rtl/gsensor_init_rom.sv - combinational index to {addr, data} lookup of the sensor init table
module gsensor_init_rom
  import gsensor_pkg::*;
(
  input  logic [2:0] index,
  output logic [5:0] addr,
  output logic [7:0] data
);

  always_comb begin
    addr = 6'h00;
    data = 8'h00;
    if (index < 3'(INIT_LEN)) begin
      addr = INIT_TABLE[index].addr;
      data = INIT_TABLE[index].data;
    end
  end

endmodule

// File: rtl/gsensor_spi_sequencer.sv
// rtl/gsensor_spi_sequencer.sv - ADXL345 power-up, init and periodic XYZ read sequencer for the SPI engine
// GSENSOR_INT_POLL_EN: trigger reads from synchronised INT1 rising edges instead of the poll timer.
module gsensor_spi_sequencer
  import gsensor_pkg::*;
#(
  parameter int POWERUP_CYCLES = 2000,
  parameter int POLL_CYCLES    = 20000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        iRSTN,
  input  logic        iSPI_CLK,
  output logic [15:0] oP2S_DATA,
  output logic        oSPI_GO,
  input  logic        iSPI_END,
  input  logic [7:0]  iS2P_DATA,
  input  logic        iG_INT1,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic [15:0] oZ,
  output logic        oDATA_VALID,
  output logic        oINIT_DONE,
  output logic        oBUSY
);

  state_t      state;
  logic [15:0] pwrCnt;
  logic [7:0]  gapCnt;
  logic [2:0]  idx;
  logic [47:0] staging;
  logic        pending;
  logic        trigger;
  logic [5:0]  romAddr;
  logic [7:0]  romData;

  gsensor_init_rom uRom (
    .index(idx),
    .addr (romAddr),
    .data (romData)
  );

`ifdef GSENSOR_INT_POLL_EN
  logic [2:0] intSync;

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) intSync <= 3'b000;
    else        intSync <= {intSync[1:0], iG_INT1};
  end

  assign trigger = oINIT_DONE && intSync[1] && !intSync[2];
`else
  logic [15:0] pollTimer;
  logic        unusedInt;

  assign unusedInt = iG_INT1;

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      pollTimer <= 16'd0;
    end else if (oINIT_DONE) begin
      if (pollTimer == 16'(POLL_CYCLES - 1)) pollTimer <= 16'd0;
      else                                   pollTimer <= pollTimer + 16'd1;
    end
  end

  assign trigger = oINIT_DONE && (pollTimer == 16'(POLL_CYCLES - 1));
`endif

  assign oBUSY = (state != S_IDLE);

  // oP2S_DATA is loaded on entry to an ISSUE state so it leads oSPI_GO by one cycle
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state       <= S_PWRUP;
      pwrCnt      <= 16'd0;
      gapCnt      <= 8'd0;
      idx         <= 3'd0;
      staging     <= 48'd0;
      pending     <= 1'b0;
      oP2S_DATA   <= 16'd0;
      oSPI_GO     <= 1'b0;
      oX          <= 16'd0;
      oY          <= 16'd0;
      oZ          <= 16'd0;
      oDATA_VALID <= 1'b0;
      oINIT_DONE  <= 1'b0;
    end else begin
      oDATA_VALID <= 1'b0;
      if (trigger && state != S_IDLE) pending <= 1'b1;

      case (state)
        S_PWRUP: begin
          pwrCnt <= pwrCnt + 16'd1;
          if (pwrCnt == 16'(POWERUP_CYCLES - 1)) begin
            state     <= S_INIT_ISSUE;
            oP2S_DATA <= cmdWord(1'b0, romAddr, romData);
          end
        end

        S_INIT_ISSUE: begin
          oSPI_GO <= 1'b1;
          state   <= S_INIT_WAIT;
        end

        S_INIT_WAIT: begin
          if (iSPI_END) begin
            oSPI_GO <= 1'b0;
            gapCnt  <= 8'd0;
            idx     <= idx + 3'd1;
            state   <= S_INIT_GAP;
          end
        end

        S_INIT_GAP: begin
          if (gapCnt == 8'(GAP_CYCLES - 1)) begin
            if (idx == 3'(INIT_LEN)) begin
              state      <= S_IDLE;
              oINIT_DONE <= 1'b1;
            end else begin
              state     <= S_INIT_ISSUE;
              oP2S_DATA <= cmdWord(1'b0, romAddr, romData);
            end
          end else begin
            gapCnt <= gapCnt + 8'd1;
          end
        end

        S_IDLE: begin
          if (trigger || pending) begin
            pending   <= 1'b0;
            idx       <= 3'd0;
            state     <= S_RD_ISSUE;
            oP2S_DATA <= cmdWord(1'b1, DATAX0, 8'h00);
          end
        end

        S_RD_ISSUE: begin
          oSPI_GO <= 1'b1;
          state   <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (iSPI_END) begin
            oSPI_GO <= 1'b0;
            gapCnt  <= 8'd0;
            idx     <= idx + 3'd1;
            state   <= S_RD_GAP;
          end
        end

        S_RD_GAP: begin
          // final bit has landed in the engine shift register one cycle after END
          if (gapCnt == 8'd0) staging <= {iS2P_DATA, staging[47:8]};
          if (gapCnt == 8'(GAP_CYCLES - 1)) begin
            if (idx == 3'(NUM_READS)) begin
              state <= S_PUBLISH;
            end else begin
              state     <= S_RD_ISSUE;
              oP2S_DATA <= cmdWord(1'b1, DATAX0 + {3'b000, idx}, 8'h00);
            end
          end else begin
            gapCnt <= gapCnt + 8'd1;
          end
        end

        S_PUBLISH: begin
          oX          <= staging[15:0];
          oY          <= staging[31:16];
          oZ          <= staging[47:32];
          oDATA_VALID <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_gsensor_spi_sequencer.sv
// tb/tb_gsensor_spi_sequencer.sv - self-checking bench with SPI engine model and trigger/timing reference model
module tb_gsensor_spi_sequencer;

  localparam int PWR  = 10;
  localparam int POLL = 50;
  localparam int GAP  = 2;
  localparam int TXN  = 1 + 16 + 1 + GAP;
  localparam int LAT  = 6 * TXN + 2;

  logic        iRSTN = 1'b0;
  logic        iSPI_CLK = 1'b0;
  logic        iSPI_END = 1'b0;
  logic [7:0]  iS2P_DATA = 8'h00;
  logic        iG_INT1 = 1'b0;
  logic [15:0] oP2S_DATA, oX, oY, oZ;
  logic        oSPI_GO, oDATA_VALID, oINIT_DONE, oBUSY;

  gsensor_spi_sequencer #(
    .POWERUP_CYCLES(PWR),
    .POLL_CYCLES   (POLL),
    .GAP_CYCLES    (GAP)
  ) dut (
    .iRSTN      (iRSTN),
    .iSPI_CLK   (iSPI_CLK),
    .oP2S_DATA  (oP2S_DATA),
    .oSPI_GO    (oSPI_GO),
    .iSPI_END   (iSPI_END),
    .iS2P_DATA  (iS2P_DATA),
    .iG_INT1    (iG_INT1),
    .oX         (oX),
    .oY         (oY),
    .oZ         (oZ),
    .oDATA_VALID(oDATA_VALID),
    .oINIT_DONE (oINIT_DONE),
    .oBUSY      (oBUSY)
  );

  always #5 iSPI_CLK = ~iSPI_CLK;

  typedef struct {
    logic [5:0][7:0] b;
    logic [15:0]     x, y, z;
  } vec_t;

  vec_t        vec [4];
  logic [15:0] initCmd [5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int initRise = -1;
  int seqN = 0;
  logic [5:0][7:0] curB;

  logic [15:0] cmdQ [$];
  int          riseQ [$];
  int          valQ [$];
  logic [15:0] vxQ [$], vyQ [$], vzQ [$];
  logic [15:0] expX [$], expY [$], expZ [$];
  int          expValid [$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever @(posedge iSPI_CLK) cyc++;

  // engine model: GO high for 17 cycles, END on the last, read byte presented with END
  initial begin
    int bitCnt;
    int ai;
    logic [15:0] cmd;
    bitCnt = 0;
    cmd = 16'h0000;
    forever begin
      @(posedge iSPI_CLK);
      #1;
      if (!iRSTN || !oSPI_GO) begin
        bitCnt = 0;
        iSPI_END = 1'b0;
      end else begin
        if (bitCnt == 0) begin
          cmd = oP2S_DATA;
          if (cmd == 16'hB200) begin
            if (seqN < 4) begin
              curB = vec[seqN].b;
              expX.push_back(vec[seqN].x);
              expY.push_back(vec[seqN].y);
              expZ.push_back(vec[seqN].z);
            end else begin
              for (int i = 0; i < 6; i++) curB[i] = 8'($urandom);
              expX.push_back({curB[1], curB[0]});
              expY.push_back({curB[3], curB[2]});
              expZ.push_back({curB[5], curB[4]});
            end
            seqN++;
          end
        end
        bitCnt++;
        iSPI_END = (bitCnt == 17);
        if (bitCnt == 17 && cmd[15]) begin
          ai = int'(cmd[13:8]) - 'h32;
          iS2P_DATA = (ai >= 0 && ai < 6) ? curB[ai] : 8'h00;
        end
      end
    end
  end

  // monitor: command log, handshake/gap rules, valid strobes
  initial begin
    logic        prevGo, prevValid, prevInit;
    logic [15:0] prevP2s;
    int          lowRun;
    prevGo = 1'b0; prevValid = 1'b0; prevInit = 1'b0; prevP2s = 16'h0; lowRun = 1000;
    forever begin
      @(negedge iSPI_CLK);
      if (!iRSTN) begin
        prevGo = 1'b0; prevValid = 1'b0; prevInit = 1'b0; prevP2s = 16'h0; lowRun = 1000;
      end else begin
        if (oSPI_GO && !prevGo) begin
          check("gap_low_cycles", lowRun >= GAP, 1'b1);
          check("p2s_setup", oP2S_DATA, prevP2s);
          cmdQ.push_back(oP2S_DATA);
          riseQ.push_back(cyc);
        end
        if (oSPI_GO && prevGo) check("p2s_hold", oP2S_DATA, prevP2s);
        if (oDATA_VALID) begin
          check("valid_width", prevValid, 1'b0);
          valQ.push_back(cyc);
          vxQ.push_back(oX);
          vyQ.push_back(oY);
          vzQ.push_back(oZ);
        end
        if (oINIT_DONE && !prevInit) initRise = cyc;
        lowRun = oSPI_GO ? 0 : lowRun + 1;
        prevGo = oSPI_GO; prevValid = oDATA_VALID; prevInit = oINIT_DONE; prevP2s = oP2S_DATA;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // trigger model: ticks every POLL cycles after init; one pending tick at most while busy
  task automatic buildModel(input int e, input int n);
    int s, t;
    expValid.delete();
    s = e + POLL;
    for (int k = 0; k < n; k++) begin
      expValid.push_back(s - 1 + LAT);
      t = ((s - e) / POLL + 1) * POLL + e;
      if (t <= s + LAT - 2) s = s + LAT;
      else s = t;
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_go"}, oSPI_GO, 1'b0);
    check({tag, "_p2s"}, oP2S_DATA, 16'h0);
    check({tag, "_valid"}, oDATA_VALID, 1'b0);
    check({tag, "_init"}, oINIT_DONE, 1'b0);
    check({tag, "_busy"}, oBUSY, 1'b1);
    check({tag, "_xyz"}, {oX, oY, oZ}, 48'h0);
  endtask

  task automatic releaseReset();
    @(negedge iSPI_CLK);
    iRSTN = 1'b1;
    cyc = 0;
    initRise = -1;
    cmdQ.delete(); riseQ.delete(); valQ.delete();
    vxQ.delete(); vyQ.delete(); vzQ.delete();
    expX.delete(); expY.delete(); expZ.delete();
  endtask

  task automatic checkInit();
    int b;
    b = 0;
    while ((cmdQ.size() < 5 || initRise < 0) && b < 400) begin
      @(negedge iSPI_CLK);
      b++;
    end
    check("init_timeout", b < 400, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (cmdQ.size() == 0) break;
      check($sformatf("init_cmd%0d", i), cmdQ.pop_front(), initCmd[i]);
      check($sformatf("init_rise%0d", i), riseQ.pop_front(), PWR + 1 + TXN * i);
    end
    check("init_done_cyc", initRise, PWR + 5 * TXN);
  endtask

  task automatic waitValids(input int n, input int budget);
    int b;
    b = 0;
    while (valQ.size() < n && b < budget) begin
      @(negedge iSPI_CLK);
      b++;
    end
    check("valid_timeout", valQ.size() >= n, 1'b1);
  endtask

  task automatic checkSample(input int k, input int expCyc);
    if (valQ.size() == 0 || expX.size() == 0) begin
      check($sformatf("sample%0d_missing", k), 1'b0, 1'b1);
    end else begin
      check($sformatf("valid_cyc%0d", k), valQ.pop_front(), expCyc);
      check($sformatf("x%0d", k), vxQ.pop_front(), expX.pop_front());
      check($sformatf("y%0d", k), vyQ.pop_front(), expY.pop_front());
      check($sformatf("z%0d", k), vzQ.pop_front(), expZ.pop_front());
    end
  endtask

  initial begin
    int b, c;
    vec[0].b = {8'h80, 8'h00, 8'hFF, 8'hFE, 8'h12, 8'h34};
    vec[0].x = 16'h1234; vec[0].y = 16'hFFFE; vec[0].z = 16'h8000;
    vec[1].b = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[1].x = 16'h0000; vec[1].y = 16'h0000; vec[1].z = 16'h0000;
    vec[2].b = {8'h55, 8'hAA, 8'h80, 8'h01, 8'h7F, 8'hFF};
    vec[2].x = 16'h7FFF; vec[2].y = 16'h8001; vec[2].z = 16'h55AA;
    vec[3].b = {8'h3C, 8'hC3, 8'hA5, 8'h5A, 8'hF0, 8'h0F};
    vec[3].x = 16'hF00F; vec[3].y = 16'hA55A; vec[3].z = 16'h3CC3;
    initCmd = '{16'h314B, 16'h2C0A, 16'h2F00, 16'h2E80, 16'h2D08};

    repeat (3) @(negedge iSPI_CLK);
    checkResetState("reset");
    releaseReset();
    checkInit();

`ifndef GSENSOR_INT_POLL_EN
    buildModel(PWR + 5 * TXN, 6);
    waitValids(6, 1200);
    for (int k = 0; k < 6; k++) checkSample(k, expValid[k]);
    if (riseQ.size() > 0) check("first_read_rise", riseQ[0], PWR + 5 * TXN + POLL + 1);
    for (int i = 0; i < 12; i++) begin
      if (cmdQ.size() == 0) break;
      check($sformatf("read_cmd%0d", i), cmdQ.pop_front(), 16'hB200 + 16'(i % 6) * 16'h0100);
    end

    b = 0;
    while (!(oSPI_GO && oP2S_DATA == 16'hB400) && b < 300) begin
      @(negedge iSPI_CLK);
      b++;
    end
    check("third_read_seen", b < 300, 1'b1);
    repeat (3) @(negedge iSPI_CLK);
    #2 iRSTN = 1'b0;
    #1 checkResetState("midreset");
    repeat (2) @(negedge iSPI_CLK);
    releaseReset();
    checkInit();
    buildModel(PWR + 5 * TXN, 1);
    waitValids(1, 400);
    checkSample(6, expValid[0]);
`else
    repeat (60) @(negedge iSPI_CLK);
    check("int_no_spurious", cmdQ.size(), 0);
    c = cyc;
    iG_INT1 = 1'b1;
    repeat (5) @(negedge iSPI_CLK);
    iG_INT1 = 1'b0;
    waitValids(1, 300);
    if (riseQ.size() > 0) check("int_start_rise", riseQ[0], c + 4);
    checkSample(0, c + 2 + LAT);
    repeat (200) @(negedge iSPI_CLK);
    check("int_one_seq_cmds", cmdQ.size(), 6);
    cmdQ.delete();
    iG_INT1 = 1'b1;
    repeat (500) @(negedge iSPI_CLK);
    check("int_held_cmds", cmdQ.size(), 6);
    check("int_held_valids", valQ.size(), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
